fetch_stage: RTL and testbench

Instruction-fetch stage and IF/ID pipeline register for the five-stage pipelined CPU. Holds the PC, selects the next PC from the control unit's `Pcsrc`, and presents the fetched instruction and PC+4 to the decode stage. It obeys the control unit's active-low `STALL` (load-use hold) and active-low `Condep` (control-hazard flush). It also keeps saturating stall and flush event counters for bring-up.

---
 rtl/fetch_stage_if.sv | 26 ++
 rtl/fetch_stage.sv | 82 ++++++++
 tb/tb_fetch_stage.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Bundles the fetch-stage control inputs, instruction-memory port and IF/ID outputs.
// The fetch stage uses the slave side; the control unit, memory or bench uses the master side.
interface fetch_stage_if;
    logic [1:0]  Pcsrc;
    logic [31:0] BranchAddr;
    logic [31:0] JumpAddr;
    logic        STALL;
    logic        Condep;
    logic [31:0] Inst;
    logic [31:0] Iaddr;
    logic [31:0] dInst;
    logic [31:0] dPC4;
    logic        dValid;
    logic [15:0] StallCnt;
    logic [15:0] FlushCnt;

    modport master (
        output Pcsrc, BranchAddr, JumpAddr, STALL, Condep, Inst,
        input  Iaddr, dInst, dPC4, dValid, StallCnt, FlushCnt
    );

    modport slave (
        input  Pcsrc, BranchAddr, JumpAddr, STALL, Condep, Inst,
        output Iaddr, dInst, dPC4, dValid, StallCnt, FlushCnt
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with the IF/ID pipeline register. Flush (Condep=0) beats
// stall (STALL=0). It also keeps saturating stall and flush event counters.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic         Clk,
    input  logic         Clrn,
    fetch_stage_if.slave fif
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] dinst_q, dinst_d;
    logic [31:0] dpc4_q, dpc4_d;
    logic        dvalid_q, dvalid_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;
    logic [31:0] pc4;
    logic [31:0] npc;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_comb begin
        pc4 = pc_q + 32'd4;
        unique case (fif.Pcsrc)
            2'b10:   npc = fif.BranchAddr;
            2'b11:   npc = fif.JumpAddr;
            default: npc = pc4;
        endcase

        pc_d        = pc_q;
        dinst_d     = dinst_q;
        dpc4_d      = dpc4_q;
        dvalid_d    = dvalid_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;

        if (!fif.Condep) begin
            pc_d        = npc;
            dinst_d     = NOP_INST;
            dpc4_d      = pc4;
            dvalid_d    = 1'b0;
            flush_cnt_d = sat_inc(flush_cnt_q);
        end else if (!fif.STALL) begin
            // Load-use hold: the same PC is re-fetched once the stall drops.
            stall_cnt_d = sat_inc(stall_cnt_q);
        end else begin
            pc_d     = npc;
            dinst_d  = fif.Inst;
            dpc4_d   = pc4;
            dvalid_d = 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            pc_q        <= RESET_PC;
            dinst_q     <= NOP_INST;
            dpc4_q      <= 32'h0;
            dvalid_q    <= 1'b0;
            stall_cnt_q <= 16'h0;
            flush_cnt_q <= 16'h0;
        end else begin
            pc_q        <= pc_d;
            dinst_q     <= dinst_d;
            dpc4_q      <= dpc4_d;
            dvalid_q    <= dvalid_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign fif.Iaddr    = pc_q;
    assign fif.dInst    = dinst_q;
    assign fif.dPC4     = dpc4_q;
    assign fif.dValid   = dvalid_q;
    assign fif.StallCnt = stall_cnt_q;
    assign fif.FlushCnt = flush_cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized self-checking bench for fetch_stage against a cycle-level reference model
// of the PC/IF-ID/counter behaviour, plus directed reset, stall, flush, saturation and wrap cases.
module tb_fetch_stage;
    localparam logic [31:0] NOP = 32'h0000_0000;

    logic clk;
    logic clrn;
    fetch_stage_if fif();

    fetch_stage #(.RESET_PC(32'h0), .NOP_INST(NOP)) dut (
        .Clk  (clk),
        .Clrn (clrn),
        .fif  (fif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] imem(input logic [31:0] a);
        if (a == 32'h0) return 32'h2001_0005;
        if (a == 32'h4) return 32'h2002_0007;
        return {a[15:0] ^ 16'hA5A5, a[31:16] + 16'h1234};
    endfunction

    assign fif.Inst = imem(fif.Iaddr);

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model state
    logic [31:0] m_pc, m_dinst, m_dpc4;
    logic        m_dvalid;
    int          m_scnt, m_fcnt;

    task automatic model_reset();
        m_pc = 32'h0; m_dinst = NOP; m_dpc4 = 32'h0; m_dvalid = 1'b0;
        m_scnt = 0; m_fcnt = 0;
    endtask

    task automatic model_edge();
        logic [31:0] target;
        case (fif.Pcsrc)
            2'b10:   target = fif.BranchAddr;
            2'b11:   target = fif.JumpAddr;
            default: target = m_pc + 32'd4;
        endcase
        if (fif.Condep == 1'b0) begin
            m_dpc4 = m_pc + 32'd4; m_dinst = NOP; m_dvalid = 1'b0;
            m_pc = target;
            m_fcnt = (m_fcnt < 65535) ? m_fcnt + 1 : 65535;
        end else if (fif.STALL == 1'b0) begin
            m_scnt = (m_scnt < 65535) ? m_scnt + 1 : 65535;
        end else begin
            m_dinst = imem(m_pc); m_dpc4 = m_pc + 32'd4; m_dvalid = 1'b1;
            m_pc = target;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".Iaddr"},    fif.Iaddr,             m_pc);
        check({tag, ".dInst"},    fif.dInst,             m_dinst);
        check({tag, ".dPC4"},     fif.dPC4,              m_dpc4);
        check({tag, ".dValid"},   {31'h0, fif.dValid},   {31'h0, m_dvalid});
        check({tag, ".StallCnt"}, {16'h0, fif.StallCnt}, m_scnt[31:0]);
        check({tag, ".FlushCnt"}, {16'h0, fif.FlushCnt}, m_fcnt[31:0]);
    endtask

    // Inputs are stable before the edge; outputs are sampled 1 time unit after it.
    task automatic tick(input string tag, input bit do_chk);
        model_edge();
        @(posedge clk);
        #1;
        if (do_chk) check_all(tag);
    endtask

    task automatic drive(input logic [1:0] ps, input logic st, input logic cd,
                         input logic [31:0] ba, input logic [31:0] ja);
        fif.Pcsrc = ps; fif.STALL = st; fif.Condep = cd;
        fif.BranchAddr = ba; fif.JumpAddr = ja;
    endtask

    initial begin
        logic [15:0] scnt_before;
        logic [15:0] fcnt_before;
        clrn = 1'b0;
        drive(2'b00, 1'b1, 1'b1, 32'h0, 32'h0);
        model_reset();
        #3;
        check_all("reset");
        check("reset.Iaddr_const", fif.Iaddr, 32'h0);
        @(negedge clk);
        clrn = 1'b1;

        // Straight-line fetch
        tick("edge1", 1'b1);
        check("edge1.dInst_const", fif.dInst, 32'h2001_0005);
        check("edge1.dPC4_const", fif.dPC4, 32'h4);
        check("edge1.Iaddr_const", fif.Iaddr, 32'h4);
        tick("edge2", 1'b1);
        check("edge2.dInst_const", fif.dInst, 32'h2002_0007);
        check("edge2.dPC4_const", fif.dPC4, 32'h8);

        // Load-use stall at PC=8 for two cycles
        drive(2'b00, 1'b0, 1'b1, 32'h0, 32'h0);
        tick("stall1", 1'b1);
        tick("stall2", 1'b1);
        check("stall.Iaddr_const", fif.Iaddr, 32'h8);
        check("stall.StallCnt_const", {16'h0, fif.StallCnt}, 32'd2);
        drive(2'b00, 1'b1, 1'b1, 32'h0, 32'h0);
        tick("resume", 1'b1);
        check("resume.Iaddr_const", fif.Iaddr, 32'hC);

        // Taken branch with flush
        drive(2'b10, 1'b1, 1'b0, 32'h40, 32'h0);
        tick("brflush", 1'b1);
        check("brflush.Iaddr_const", fif.Iaddr, 32'h40);
        check("brflush.dValid_const", {31'h0, fif.dValid}, 32'h0);
        check("brflush.FlushCnt_const", {16'h0, fif.FlushCnt}, 32'd1);
        drive(2'b00, 1'b1, 1'b1, 32'h0, 32'h0);
        tick("postbr", 1'b1);
        check("postbr.dValid_const", {31'h0, fif.dValid}, 32'h1);

        // Flush and stall in the same cycle
        scnt_before = fif.StallCnt;
        fcnt_before = fif.FlushCnt;
        drive(2'b11, 1'b0, 1'b0, 32'h0, 32'h100);
        tick("flst", 1'b1);
        check("flst.Iaddr_const", fif.Iaddr, 32'h100);
        check("flst.dInst_const", fif.dInst, NOP);
        check("flst.StallCnt_hold", {16'h0, fif.StallCnt}, {16'h0, scnt_before});
        check("flst.FlushCnt_inc", {16'h0, fif.FlushCnt}, {16'h0, fcnt_before + 16'd1});

        // Redirect without flush (delay slot) and randomized traffic
        for (int i = 0; i < 300; i++) begin
            logic [1:0] ps;
            ps = 2'($urandom_range(0, 3));
            drive(ps, ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) != 0),
                  {$urandom} & 32'hFFFF_FFFC, {$urandom} & 32'hFFFF_FFFC);
            tick("rand", 1'b1);
            // Mid-cycle glitch on control inputs must not matter
            fif.STALL = ~fif.STALL; fif.Condep = ~fif.Condep; fif.Pcsrc = ~fif.Pcsrc;
            #2;
        end

        // Asynchronous reset between edges at Iaddr=0x40 with nonzero counters
        drive(2'b00, 1'b0, 1'b1, 32'h0, 32'h0);
        tick("prestall", 1'b1);
        drive(2'b10, 1'b1, 1'b0, 32'h40, 32'h0);
        tick("pre_arst", 1'b1);
        check("pre_arst.Iaddr_const", fif.Iaddr, 32'h40);
        #2;
        clrn = 1'b0;
        model_reset();
        #1;
        check_all("arst");
        #1;
        clrn = 1'b1;
        drive(2'b00, 1'b1, 1'b1, 32'h0, 32'h0);
        tick("post_arst", 1'b1);
        check("post_arst.dInst_const", fif.dInst, 32'h2001_0005);

        // Stall counter saturation
        drive(2'b00, 1'b0, 1'b1, 32'h0, 32'h0);
        for (int i = 0; i < 65540; i++) tick("sat", 1'b0);
        check_all("sat");
        check("sat.StallCnt_const", {16'h0, fif.StallCnt}, 32'h0000_FFFF);

        // PC wrap
        drive(2'b11, 1'b1, 1'b1, 32'h0, 32'hFFFF_FFFC);
        tick("jmpwrap", 1'b1);
        check("jmpwrap.Iaddr_const", fif.Iaddr, 32'hFFFF_FFFC);
        drive(2'b00, 1'b1, 1'b1, 32'h0, 32'h0);
        tick("wrap", 1'b1);
        check("wrap.Iaddr_const", fif.Iaddr, 32'h0);
        check("wrap.dPC4_const", fif.dPC4, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
